// File: rtl/ttest_mac_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ttest_mac_pipe_if
// Description : Operand and result bundle for the pipelined multiplier /
//               accumulator. The master drives operands, stall and tags.
//               The slave returns the product and accumulator results.
// Revision    : 1.0 - initial release
// ============================================================================
interface ttest_mac_pipe_if #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 40,
  parameter int ACC_WIDTH  = 48
);
  logic                  ce;
  logic                  in_valid;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  acc_en;
  logic                  acc_clr;
  logic                  out_valid;
  logic [dout_WIDTH-1:0] dout;
  logic                  acc_valid;
  logic [ACC_WIDTH-1:0]  acc_out;

  modport master (
    output ce, in_valid, din0, din1, acc_en, acc_clr,
    input  out_valid, dout, acc_valid, acc_out
  );

  modport slave (
    input  ce, in_valid, din0, din1, acc_en, acc_clr,
    output out_valid, dout, acc_valid, acc_out
  );
endinterface
`default_nettype wire

// File: rtl/ttest_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ttest_mac_pipe
// Description : Pipelined multiplier with per-operand signedness, valid/tag
//               tracking through NUM_STAGE registers, and a running
//               accumulator with clear-and-load. ce=0 freezes everything.
// Revision    : 1.0 - initial release
// ============================================================================
module ttest_mac_pipe #(
  parameter int din0_WIDTH  = 32,
  parameter int din1_WIDTH  = 8,
  parameter int dout_WIDTH  = 40,
  parameter int NUM_STAGE   = 2,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int ACC_WIDTH   = 48
) (
  input  wire logic       clk,
  input  wire logic       reset,
  ttest_mac_pipe_if.slave bus
);

  // One extra bit per operand lets a single signed multiplier serve every
  // signed/unsigned combination.
  localparam int PROD_WIDTH = din0_WIDTH + din1_WIDTH + 2;
  localparam bit ANY_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  logic                         a_top;
  logic                         b_top;
  logic signed [din0_WIDTH:0]   a_ext;
  logic signed [din1_WIDTH:0]   b_ext;
  logic signed [PROD_WIDTH-1:0] prod_full;
  logic [dout_WIDTH-1:0]        prod_rs;

  // Pipeline storage: product plus valid and accumulate tags per stage.
  logic [dout_WIDTH-1:0] prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]  valid_q;
  logic [NUM_STAGE-1:0]  en_q;
  logic [NUM_STAGE-1:0]  clr_q;

  logic                  last_valid;
  logic                  last_en;
  logic                  last_clr;
  logic [dout_WIDTH-1:0] last_prod;

  logic [ACC_WIDTH-1:0]  prod_acc_ext;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic                  acc_load;
  logic                  acc_valid_q;

  // Operand widening: sign bit for signed operands, zero otherwise.
  assign a_top = (DIN0_SIGNED != 0) ? bus.din0[din0_WIDTH-1] : 1'b0;
  assign b_top = (DIN1_SIGNED != 0) ? bus.din1[din1_WIDTH-1] : 1'b0;
  assign a_ext = {a_top, bus.din0};
  assign b_ext = {b_top, bus.din1};

  // Full-precision signed product; never overflows PROD_WIDTH.
  assign prod_full = PROD_WIDTH'(a_ext) * PROD_WIDTH'(b_ext);

  // Fit the product to dout_WIDTH: extend when wider, keep low bits otherwise.
  if (dout_WIDTH > PROD_WIDTH) begin : g_dout_ext
    assign prod_rs = {{(dout_WIDTH-PROD_WIDTH){ANY_SIGNED & prod_full[PROD_WIDTH-1]}},
                      prod_full};
  end else if (dout_WIDTH == PROD_WIDTH) begin : g_dout_same
    assign prod_rs = prod_full;
  end else begin : g_dout_trunc
    logic unused_prod_hi;
    assign prod_rs        = prod_full[dout_WIDTH-1:0];
    assign unused_prod_hi = ^prod_full[PROD_WIDTH-1:dout_WIDTH];
  end

  // Stage shift register: stage 0 captures the fresh product, later stages retime.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= '0;
      end
      valid_q <= '0;
      en_q    <= '0;
      clr_q   <= '0;
    end else if (bus.ce) begin
      prod_q[0]  <= prod_rs;
      valid_q[0] <= bus.in_valid;
      // Tags on bubbles are dropped here so they can never reach the accumulator.
      en_q[0]    <= bus.in_valid & bus.acc_en;
      clr_q[0]   <= bus.in_valid & bus.acc_clr;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i]  <= prod_q[i-1];
        valid_q[i] <= valid_q[i-1];
        en_q[i]    <= en_q[i-1];
        clr_q[i]   <= clr_q[i-1];
      end
    end
  end

  assign last_valid = valid_q[NUM_STAGE-1];
  assign last_en    = en_q[NUM_STAGE-1];
  assign last_clr   = clr_q[NUM_STAGE-1];
  assign last_prod  = prod_q[NUM_STAGE-1];

  // Accumulator operand uses the same sign/zero rule as the product resize.
  if (ACC_WIDTH > dout_WIDTH) begin : g_acc_ext
    assign prod_acc_ext = {{(ACC_WIDTH-dout_WIDTH){ANY_SIGNED & last_prod[dout_WIDTH-1]}},
                           last_prod};
  end else begin : g_acc_same
    assign prod_acc_ext = last_prod[ACC_WIDTH-1:0];
  end

  // Accumulator update selection: clear-and-load beats add; no tag holds.
  always_comb begin
    acc_load = 1'b0;
    acc_next = acc_q;
    if (last_valid && last_clr) begin
      acc_load = 1'b1;
      acc_next = prod_acc_ext;
    end else if (last_valid && last_en) begin
      acc_load = 1'b1;
      acc_next = acc_q + prod_acc_ext;
    end
  end

  // Accumulator register; acc_valid pulses only when the value was written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
    end else if (bus.ce) begin
      acc_q       <= acc_next;
      acc_valid_q <= acc_load;
    end
  end

  assign bus.out_valid = last_valid;
  assign bus.dout      = last_prod;
  assign bus.acc_valid = acc_valid_q;
  assign bus.acc_out   = acc_q;

endmodule
`default_nettype wire
